// File: rtl/io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_pkg : shared widths and edge-mode encoding for the I/O front end  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package io_pkg;

  localparam int ENC_CNT_W    = 16;
  localparam int ENC_PER_W    = 16;
  localparam int ENC_FILT_LEN = 4;

  typedef enum logic [0:0] {
    EDGE_RISING = 1'b0,
    EDGE_BOTH   = 1'b1
  } edge_mode_e;

endpackage
`default_nettype wire

// File: rtl/glitch_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | glitch_filter : 2-flop synchroniser plus stable-sample level filter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module glitch_filter import io_pkg::*; #(
  parameter int FILT_LEN = ENC_FILT_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt,
  output logic o_accept
);

  localparam logic [3:0] c_LAST = 4'(FILT_LEN - 1);

  logic       r_s1;
  logic       r_s2;
  logic       r_filt;
  logic [3:0] r_fcnt;
  logic       w_diff;
  logic       w_accept;

  assign w_diff   = (r_s2 != r_filt);
  // Accept strobe is decoded from registered state so the consumer can act on it this edge.
  assign w_accept = w_diff && (r_fcnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_fcnt <= 4'd0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (!w_diff) begin
        r_fcnt <= 4'd0;
      end else if (w_accept) begin
        r_filt <= r_s2;
        r_fcnt <= 4'd0;
      end else begin
        r_fcnt <= r_fcnt + 4'd1;
      end
    end
  end

  assign o_filt   = r_filt;
  assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/encoder_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | encoder_tick_counter : filtered edge count, snapshot and period timer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module encoder_tick_counter import io_pkg::*; #(
  parameter int FILT_LEN  = ENC_FILT_LEN,
  parameter int EDGE_MODE = int'(EDGE_RISING),
  parameter int CNT_W     = ENC_CNT_W,
  parameter int PER_W     = ENC_PER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_in,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] snap_count,
  output logic [PER_W-1:0] period,
  output logic             stalled,
  output logic             edge_pulse
);

  localparam logic [PER_W-1:0] c_PER_MAX = {PER_W{1'b1}};

  logic             w_filt;
  logic             w_accept;
  logic             w_qual;
  logic [PER_W-1:0] w_tmr_inc;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_snap_count;
  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] r_tmr;
  logic             r_stalled;
  logic             r_edge_pulse;

  glitch_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (enc_in),
    .o_filt   (w_filt),
    .o_accept (w_accept)
  );

  // The filtered level is still the old one on the accept edge, so a rising edge is old level 0.
  generate
    if (EDGE_MODE == int'(EDGE_BOTH)) begin : g_both_edges
      assign w_qual = w_accept;
    end else begin : g_rising_edge
      assign w_qual = w_accept & ~w_filt;
    end
  endgenerate

  assign w_tmr_inc = (r_tmr == c_PER_MAX) ? r_tmr : r_tmr + PER_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_snap_count <= '0;
      r_period     <= c_PER_MAX;
      r_tmr        <= '0;
      r_stalled    <= 1'b1;
      r_edge_pulse <= 1'b0;
    end else begin
      r_edge_pulse <= w_qual;

      if (snap) begin
        r_snap_count <= r_count;
      end

      if (clr) begin
        r_count <= '0;
      end else if (w_qual) begin
        r_count <= r_count + CNT_W'(1);
      end

      if (w_qual) begin
        r_period  <= w_tmr_inc;
        r_tmr     <= '0;
        r_stalled <= 1'b0;
      end else begin
        r_tmr <= w_tmr_inc;
        // Once the timer pins at full scale the last period is no longer meaningful.
        if (w_tmr_inc == c_PER_MAX) begin
          r_period  <= c_PER_MAX;
          r_stalled <= 1'b1;
        end
      end
    end
  end

  assign count      = r_count;
  assign snap_count = r_snap_count;
  assign period     = r_period;
  assign stalled    = r_stalled;
  assign edge_pulse = r_edge_pulse;

endmodule
`default_nettype wire

// File: tb/tb_encoder_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_encoder_tick_counter : two-instance self-checking bench           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_encoder_tick_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_a, clr_a, snap_a;
  logic        enc_b, clr_b, snap_b;
  logic [15:0] count_a, snap_count_a, period_a;
  logic [15:0] count_b, snap_count_b, period_b;
  logic        stalled_a, edge_pulse_a, stalled_b, edge_pulse_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // A: default filter, rising edges only.  B: single-sample filter, both edges.
  encoder_tick_counter #(.FILT_LEN(4), .EDGE_MODE(0), .CNT_W(16), .PER_W(16)) dut_a (
    .clk(clk), .rst(rst), .enc_in(enc_a), .clr(clr_a), .snap(snap_a),
    .count(count_a), .snap_count(snap_count_a), .period(period_a),
    .stalled(stalled_a), .edge_pulse(edge_pulse_a));

  encoder_tick_counter #(.FILT_LEN(1), .EDGE_MODE(1), .CNT_W(16), .PER_W(16)) dut_b (
    .clk(clk), .rst(rst), .enc_in(enc_b), .clr(clr_b), .snap(snap_b),
    .count(count_b), .snap_count(snap_count_b), .period(period_b),
    .stalled(stalled_b), .edge_pulse(edge_pulse_b));

  // Reference: an edge is accepted when the last FILT_LEN synchronised samples all
  // disagree with the current filtered level; "since" is clocks since the last edge.
  typedef struct {
    logic [15:0] hist;
    logic        filt;
    logic [15:0] count;
    logic [15:0] snapv;
    logic [15:0] period;
    logic        stalled;
    logic        pulse;
    int unsigned since;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_step(model_t m, int flen, bit both,
                                        logic r, logic enc, logic c, logic s);
    bit acc;
    bit qual;
    if (r) begin
      m.hist = '0; m.filt = 1'b0; m.count = '0; m.snapv = '0;
      m.period = 16'hFFFF; m.stalled = 1'b1; m.pulse = 1'b0; m.since = 0;
      return m;
    end
    acc = 1'b1;
    for (int i = 1; i <= flen; i++) if (m.hist[i] == m.filt) acc = 1'b0;
    qual = acc && (!m.filt || both);
    if (acc) m.filt = !m.filt;
    if (s) m.snapv = m.count;
    if (c) m.count = '0;
    else if (qual) m.count = m.count + 16'd1;
    m.pulse = qual;
    if (qual) begin
      m.period  = (m.since + 1 > 65535) ? 16'hFFFF : 16'(m.since + 1);
      m.since   = 0;
      m.stalled = 1'b0;
    end else begin
      if (m.since < 65535) m.since++;
      if (m.since == 65535) begin
        m.period  = 16'hFFFF;
        m.stalled = 1'b1;
      end
    end
    m.hist = {m.hist[14:0], enc};
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ma = model_step(ma, 4, 1'b0, rst, enc_a, clr_a, snap_a);
    mb = model_step(mb, 1, 1'b1, rst, enc_b, clr_b, snap_b);
    #1;
    check("a.count", count_a, ma.count);
    check("a.snap", snap_count_a, ma.snapv);
    check("a.period", period_a, ma.period);
    check("a.stalled", stalled_a, ma.stalled);
    check("a.pulse", edge_pulse_a, ma.pulse);
    check("b.count", count_b, mb.count);
    check("b.snap", snap_count_b, mb.snapv);
    check("b.period", period_b, mb.period);
    check("b.stalled", stalled_b, mb.stalled);
    check("b.pulse", edge_pulse_b, mb.pulse);
  endtask

  typedef struct {
    logic enc;
    int   cycles;
    int   exp_count;
    int   exp_pulses;
    bit   chk_per;
    int   exp_per;
  } seg_t;

  seg_t tbl[40];
  int   n_seg;

  initial begin
    int np;
    int run_left;

    // Square wave (40 clocks) followed by glitch pulses on instance A.
    n_seg = 0;
    for (int i = 0; i < 10; i++) begin
      tbl[n_seg++] = '{1'b0, 20, 1 + i, 0, 1'b0, 0};
      tbl[n_seg++] = '{1'b1, 20, 2 + i, 1, (i > 0), 40};
    end
    tbl[n_seg++] = '{1'b0, 20, 11, 0, 1'b0, 0};
    for (int i = 0; i < 3; i++) begin
      tbl[n_seg++] = '{1'b1, 3, 11, 0, 1'b0, 0};
      tbl[n_seg++] = '{1'b0, 20, 11, 0, 1'b0, 0};
    end
    tbl[n_seg++] = '{1'b1, 4, 11, 0, 1'b0, 0};
    tbl[n_seg++] = '{1'b0, 20, 12, 1, 1'b0, 0};

    rst = 1'b1;
    enc_a = 1'b0; clr_a = 1'b0; snap_a = 1'b0;
    enc_b = 1'b0; clr_b = 1'b0; snap_b = 1'b0;
    repeat (3) tick();
    check("rst.count", count_a, 0);
    check("rst.snap", snap_count_a, 0);
    check("rst.period", period_a, 16'hFFFF);
    check("rst.stalled", stalled_a, 1);
    check("rst.pulse", edge_pulse_a, 0);

    rst = 1'b0;
    np = 0;
    repeat (100) begin
      tick();
      np += int'(edge_pulse_a) + int'(edge_pulse_b);
    end
    check("idle.count", count_a, 0);
    check("idle.pulses", np, 0);
    check("idle.period", period_a, 16'hFFFF);
    check("idle.stalled", stalled_a, 1);

    // Latency: first sampled at edge k, qualified at edge k+5.
    enc_a = 1'b1;
    tick();
    repeat (4) tick();
    check("lat.count_early", count_a, 0);
    check("lat.pulse_early", edge_pulse_a, 0);
    tick();
    check("lat.count", count_a, 1);
    check("lat.pulse", edge_pulse_a, 1);
    check("lat.stalled", stalled_a, 0);
    check("lat.period_since_rst", period_a, 106);
    tick();
    check("lat.pulse_once", edge_pulse_a, 0);

    for (int s = 0; s < n_seg; s++) begin
      enc_a = tbl[s].enc;
      np = 0;
      repeat (tbl[s].cycles) begin
        tick();
        np += int'(edge_pulse_a);
      end
      check($sformatf("seg%0d.count", s), count_a, tbl[s].exp_count);
      check($sformatf("seg%0d.pulses", s), np, tbl[s].exp_pulses);
      if (tbl[s].chk_per) check($sformatf("seg%0d.period", s), period_a, tbl[s].exp_per);
    end

    // B: preload to 0x1234, then snap + clr coinciding with a qualified edge.
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    check("b.clr", count_b, 0);
    for (int i = 0; i < 16'h1234; i++) begin
      enc_b = ~enc_b;
      tick();
    end
    repeat (4) tick();
    check("b.preload", count_b, 16'h1234);
    enc_b = ~enc_b;
    tick(); tick();
    snap_b = 1'b1; clr_b = 1'b1;
    tick();
    snap_b = 1'b0; clr_b = 1'b0;
    check("strobe.snap", snap_count_b, 16'h1234);
    check("strobe.count", count_b, 0);
    check("strobe.pulse", edge_pulse_b, 1);
    repeat (4) tick();
    check("strobe.hold", count_b, 0);

    // A: 100-clock edges then idle to saturation; B toggles toward wrap meanwhile.
    for (int t = 0; t < 65941; t++) begin
      enc_a = (t < 500) ? ((t % 100) < 50) : 1'b0;
      if (t < 65534) enc_b = ~enc_b;
      tick();
      if (t == 499) begin
        check("stall.period100", period_a, 100);
        check("stall.running", stalled_a, 0);
      end
      if (t == 65939) begin
        check("stall.edge_minus1", stalled_a, 0);
        check("stall.period_kept", period_a, 100);
      end
      if (t == 65940) begin
        check("stall.stalled", stalled_a, 1);
        check("stall.period_max", period_a, 16'hFFFF);
      end
    end
    check("b.fffe", count_b, 16'hFFFE);
    enc_a = 1'b1;
    repeat (6) tick();
    check("stall.cleared", stalled_a, 0);
    check("stall.sat_period", period_a, 16'hFFFF);
    check("stall.count", count_a, 18);
    enc_b = ~enc_b; repeat (4) tick();
    check("wrap.ffff", count_b, 16'hFFFF);
    enc_b = ~enc_b; repeat (4) tick();
    check("wrap.zero", count_b, 0);

    // Random traffic on both instances, one reset in the middle.
    run_left = 0;
    for (int t = 0; t < 1500; t++) begin
      if (run_left == 0) begin
        enc_a = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 10);
      end
      run_left--;
      enc_b  = 1'($urandom_range(0, 1));
      clr_a  = ($urandom_range(0, 31) == 0);
      clr_b  = ($urandom_range(0, 31) == 0);
      snap_a = ($urandom_range(0, 7) == 0);
      snap_b = ($urandom_range(0, 7) == 0);
      rst    = (t == 700);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
